// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO drain-side stream reader.
// State encoding and skid buffer sizing used by fifo_stream_reader and stream_skid_buf.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int FLIGHT_W   = OCC_W + 1;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer with head-slot output; push and pop may coincide.
// With FIFO_STREAM_READER_LAST_EN defined, a one-bit tag travels with each entry.
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
`ifdef FIFO_STREAM_READER_LAST_EN
  input  logic                  push_tag,
  output logic                  head_tag,
`endif
  input  logic                  pop,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  pop_ok;

  assign pop_ok    = pop && (occupancy != '0);
  assign valid     = (occupancy != '0);
  assign head_data = slot0;

  // slot0 is always the head; slot1 only holds data when two entries are live
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      slot0     <= '0;
      slot1     <= '0;
    end else begin
      case (occupancy)
        OCC_W'(0): begin
          if (push) slot0 <= push_data;
        end
        OCC_W'(1): begin
          if (push && pop_ok) slot0 <= push_data;
          else if (push)      slot1 <= push_data;
        end
        default: begin
          if (pop_ok) begin
            slot0 <= slot1;
            if (push) slot1 <= push_data;
          end
        end
      endcase
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop_ok);
    end
  end

`ifdef FIFO_STREAM_READER_LAST_EN
  logic tag0;
  logic tag1;

  assign head_tag = tag0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag0 <= 1'b0;
      tag1 <= 1'b0;
    end else begin
      case (occupancy)
        OCC_W'(0): begin
          if (push) tag0 <= push_tag;
        end
        OCC_W'(1): begin
          if (push && pop_ok) tag0 <= push_tag;
          else if (push)      tag1 <= push_tag;
        end
        default: begin
          if (pop_ok) begin
            tag0 <= tag1;
            if (push) tag1 <= push_tag;
          end
        end
      endcase
    end
  end
`endif

  assert property (@(posedge clk) disable iff (rst)
    occupancy <= OCC_W'(SKID_DEPTH));

  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_ok && (occupancy == OCC_W'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a burst of words from a synchronous FIFO and presents them as a valid/ready stream.
// Optional m_last output is enabled by defining FIFO_STREAM_READER_LAST_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
`ifdef FIFO_STREAM_READER_LAST_EN
  output logic                  m_last,
`endif
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  rd_pending_p1;
  logic                  pop;
  logic [OCC_W-1:0]      occupancy;
  logic [FLIGHT_W-1:0]   in_flight;

  assign pop = m_valid && m_ready;

  // Words that will sit in the skid buffer after this edge: current entries,
  // plus the read whose data lands now, minus the word leaving downstream.
  assign in_flight = FLIGHT_W'(occupancy) + FLIGHT_W'(rd_pending_p1) - FLIGHT_W'(pop);

  assign fifo_rd_en = (state == ST_RUN) && !fifo_empty && (remaining != '0)
                      && (in_flight < FLIGHT_W'(SKID_DEPTH));
  assign fifo_rd_cs = fifo_rd_en;

  // Control FSM: busy/done are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            remaining <= burst_len;
            if (burst_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (fifo_rd_en) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (in_flight == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: FIFO read latency; data for a read issued last cycle is on fifo_data now
  always_ff @(posedge clk) begin
    if (rst) rd_pending_p1 <= 1'b0;
    else     rd_pending_p1 <= fifo_rd_en;
  end

`ifdef FIFO_STREAM_READER_LAST_EN
  logic last_pending_p1;
  logic head_tag;

  always_ff @(posedge clk) begin
    if (rst) last_pending_p1 <= 1'b0;
    else     last_pending_p1 <= fifo_rd_en && (remaining == LEN_WIDTH'(1));
  end

  assign m_last = m_valid && head_tag;
`endif

  // Stage p2: skid buffer absorbs reads that were in flight when ready dropped
  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending_p1),
    .push_data (fifo_data),
`ifdef FIFO_STREAM_READER_LAST_EN
    .push_tag  (last_pending_p1),
    .head_tag  (head_tag),
`endif
    .pop       (pop),
    .occupancy (occupancy),
    .valid     (m_valid),
    .head_data (m_data)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader with a queue-based FIFO model and stream scoreboard.
// Covers m_last when FIFO_STREAM_READER_LAST_EN is defined.
module tb_fifo_stream_reader;
  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  busy;
  logic                  done;
  logic                  fifo_empty = 1'b1;
  logic                  fifo_rd_cs;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data = '0;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
`ifdef FIFO_STREAM_READER_LAST_EN
  logic                  m_last;
`endif
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [DATA_WIDTH-1:0] fq[$];
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] got_q[$];
  logic                  got_last_q[$];
  int rd_cnt, acc_cnt, rd_while_empty, cs_mismatch, stab_viol, done_cnt;
  int last_acc_cyc, done_cyc, underflow, max_out, last_no_valid;
  logic                  prev_stall;
  logic [DATA_WIDTH-1:0] prev_data;

  fifo_stream_reader #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_empty (fifo_empty),
    .fifo_rd_cs (fifo_rd_cs),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
`ifdef FIFO_STREAM_READER_LAST_EN
    .m_last     (m_last),
`endif
    .m_ready    (m_ready),
    .m_data     (m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO with registered read data; reset together with the reader
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        if (fq.size() > 0) fifo_data <= fq.pop_front();
        else underflow++;
      end
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Stream observer: records accepted words and protocol events for the tests
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        if (fifo_empty) rd_while_empty++;
      end
      if (fifo_rd_cs !== fifo_rd_en) cs_mismatch++;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stab_viol++;
      if (m_valid && m_ready) begin
        acc_cnt++;
        got_q.push_back(m_data);
        last_acc_cyc = cyc;
`ifdef FIFO_STREAM_READER_LAST_EN
        got_last_q.push_back(m_last);
`endif
      end
`ifdef FIFO_STREAM_READER_LAST_EN
      if (m_last && !m_valid) last_no_valid++;
`endif
      if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_cnt = 0; acc_cnt = 0; rd_while_empty = 0; cs_mismatch = 0; stab_viol = 0;
    done_cnt = 0; last_acc_cyc = -1; done_cyc = -1; underflow = 0; max_out = 0;
    last_no_valid = 0; prev_stall = 1'b0;
    got_q.delete();
    got_last_q.delete();
  endtask

  task automatic flush();
    tick();
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; m_ready = 1'b0;
    tick();
    rst = 1'b0;
    clear_mon();
    exp_q.delete();
  endtask

  task automatic fifo_write_words(input int n, input logic [DATA_WIDTH-1:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      tick();
      wr_en   = 1'b1;
      wr_data = rnd ? {$urandom(), $urandom()} : base + DATA_WIDTH'(i);
      exp_q.push_back(wr_data);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; burst_len = '0; wr_en = 1'b0; wr_data = '0; m_ready = 1'b0;
    tick(); tick();
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); else n_pass++;
    n_total++; if (fifo_rd_cs !== 1'b0) $display("FAIL reset_rd_cs got %b want 0", fifo_rd_cs); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== '0) $display("FAIL reset_m_data got %h want 0", m_data); else n_pass++;
`ifdef FIFO_STREAM_READER_LAST_EN
    n_total++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else n_pass++;
`endif
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_burst4();
    logic exp_rd, exp_vld, exp_done, exp_busy;
    logic [DATA_WIDTH-1:0] exp_d;
    flush();
    m_ready = 1'b1;
    fifo_write_words(4, DATA_WIDTH'(64'hA0), 1'b0);
    start = 1'b1; burst_len = LEN_WIDTH'(4);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      #1;
      exp_rd   = (c >= 1 && c <= 4);
      exp_vld  = (c >= 3 && c <= 6);
      exp_done = (c == 7);
      exp_busy = (c >= 1 && c <= 6);
      n_total++; if (fifo_rd_en !== exp_rd) $display("FAIL b4_rd_en c%0d got %b want %b", c, fifo_rd_en, exp_rd); else n_pass++;
      n_total++; if (m_valid !== exp_vld) $display("FAIL b4_m_valid c%0d got %b want %b", c, m_valid, exp_vld); else n_pass++;
      n_total++; if (done !== exp_done) $display("FAIL b4_done c%0d got %b want %b", c, done, exp_done); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL b4_busy c%0d got %b want %b", c, busy, exp_busy); else n_pass++;
      if (exp_vld) begin
        exp_d = DATA_WIDTH'(64'hA0) + DATA_WIDTH'(c - 3);
        n_total++; if (m_data !== exp_d) $display("FAIL b4_m_data c%0d got %h want %h", c, m_data, exp_d); else n_pass++;
      end
    end
  endtask

  task automatic test_zero_len();
    flush();
    m_ready = 1'b1;
    fifo_write_words(2, DATA_WIDTH'(64'h55), 1'b0);
    start = 1'b1; burst_len = '0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      #1;
      n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL zl_rd_en c%0d got %b want 0", c, fifo_rd_en); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL zl_busy c%0d got %b want 0", c, busy); else n_pass++;
      n_total++; if (done !== (c == 1)) $display("FAIL zl_done c%0d got %b want %b", c, done, (c == 1)); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit seen_done;
    seen_done = 1'b0;
    flush();
    m_ready = 1'b1;
    fifo_write_words(8, '0, 1'b1);
    start = 1'b1; burst_len = LEN_WIDTH'(8);
    for (int c = 0; c < 80 && !seen_done; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      m_ready = !(c >= 3 && c <= 10);
      #1;
      if (c >= 3 && c <= 10) begin
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_stall_rd_en c%0d got %b want 0", c, fifo_rd_en); else n_pass++;
        n_total++; if (m_valid !== 1'b1 || m_data !== exp_q[0])
          $display("FAIL bp_hold c%0d got v=%b d=%h want v=1 d=%h", c, m_valid, m_data, exp_q[0]); else n_pass++;
      end
      if (c == 10) begin
        n_total++; if (rd_cnt !== 2) $display("FAIL bp_outstanding got %0d want 2", rd_cnt); else n_pass++;
      end
      if (done) seen_done = 1'b1;
    end
    tick();
    n_total++; if (!seen_done) $display("FAIL bp_timeout got no done want done"); else n_pass++;
    n_total++; if (got_q.size() !== 8) $display("FAIL bp_count got %0d want 8", got_q.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_word%0d got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (max_out > 2) $display("FAIL bp_max_out got %0d want <=2", max_out); else n_pass++;
    n_total++; if (stab_viol !== 0) $display("FAIL bp_stability got %0d want 0", stab_viol); else n_pass++;
  endtask

  task automatic test_slow_fifo();
    bit seen_done;
    int written;
    seen_done = 1'b0;
    written = 0;
    flush();
    m_ready = 1'b1;
    start = 1'b1; burst_len = LEN_WIDTH'(3);
    for (int c = 0; c < 80 && !seen_done; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      wr_en = (c % 3 == 2) && (written < 3);
      if (wr_en) begin
        wr_data = {$urandom(), $urandom()};
        exp_q.push_back(wr_data);
        written++;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (done) seen_done = 1'b1;
    end
    wr_en = 1'b0;
    tick();
    n_total++; if (!seen_done) $display("FAIL slow_timeout got no done want done"); else n_pass++;
    n_total++; if (rd_while_empty !== 0) $display("FAIL slow_rd_while_empty got %0d want 0", rd_while_empty); else n_pass++;
    n_total++; if (got_q.size() !== 3) $display("FAIL slow_count got %0d want 3", got_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL slow_word%0d got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (done_cyc !== last_acc_cyc + 1)
      $display("FAIL slow_done_timing got cycle %0d want %0d", done_cyc, last_acc_cyc + 1); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL slow_done_count got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit reached, seen_done;
    reached = 1'b0;
    seen_done = 1'b0;
    flush();
    m_ready = 1'b1;
    fifo_write_words(6, '0, 1'b1);
    start = 1'b1; burst_len = LEN_WIDTH'(6);
    for (int c = 0; c < 30 && !reached; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      #1;
      if (got_q.size() >= 2) reached = 1'b1;
    end
    n_total++; if (!reached) $display("FAIL rm_progress got %0d words want 2", got_q.size()); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rm_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rm_done got %b want 0", done); else n_pass++;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL rm_rd_en got %b want 0", fifo_rd_en); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL rm_m_valid got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== '0) $display("FAIL rm_m_data got %h want 0", m_data); else n_pass++;
    clear_mon();
    exp_q.delete();
    fifo_write_words(2, '0, 1'b1);
    start = 1'b1; burst_len = LEN_WIDTH'(2);
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      #1;
      if (done) seen_done = 1'b1;
    end
    tick();
    n_total++; if (!seen_done) $display("FAIL rm_restart_timeout got no done want done"); else n_pass++;
    n_total++; if (got_q.size() !== 2) $display("FAIL rm_restart_count got %0d want 2", got_q.size()); else n_pass++;
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL rm_word%0d got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit seen_done;
    int len, pre, written;
    for (int it = 0; it < 6; it++) begin
      seen_done = 1'b0;
      flush();
      m_ready = 1'b1;
      len = $urandom_range(1, 12);
      pre = $urandom_range(0, len);
      written = pre;
      if (pre > 0) fifo_write_words(pre, '0, 1'b1);
      start = 1'b1; burst_len = LEN_WIDTH'(len);
      for (int c = 0; c < 300 && !seen_done; c++) begin
        if (c > 0) begin
          tick();
          start = 1'b0;
        end
        wr_en = (written < len) && ($urandom_range(0, 1) == 1);
        if (wr_en) begin
          wr_data = {$urandom(), $urandom()};
          exp_q.push_back(wr_data);
          written++;
        end
        m_ready = 1'($urandom_range(0, 1));
        #1;
        if (done) seen_done = 1'b1;
      end
      wr_en = 1'b0;
      tick();
      n_total++; if (!seen_done) $display("FAIL rnd%0d_timeout got no done want done", it); else n_pass++;
      n_total++; if (got_q.size() !== len) $display("FAIL rnd%0d_count got %0d want %0d", it, got_q.size(), len); else n_pass++;
      for (int i = 0; i < len && i < got_q.size(); i++) begin
        n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL rnd%0d_word%0d got %h want %h", it, i, got_q[i], exp_q[i]); else n_pass++;
      end
      n_total++; if (rd_cnt !== len) $display("FAIL rnd%0d_reads got %0d want %0d", it, rd_cnt, len); else n_pass++;
      n_total++; if (done_cnt !== 1) $display("FAIL rnd%0d_done_count got %0d want 1", it, done_cnt); else n_pass++;
      n_total++; if (max_out > 2) $display("FAIL rnd%0d_max_out got %0d want <=2", it, max_out); else n_pass++;
      n_total++; if (rd_while_empty !== 0 || underflow !== 0)
        $display("FAIL rnd%0d_empty_read got %0d/%0d want 0/0", it, rd_while_empty, underflow); else n_pass++;
      n_total++; if (stab_viol !== 0) $display("FAIL rnd%0d_stability got %0d want 0", it, stab_viol); else n_pass++;
      n_total++; if (cs_mismatch !== 0) $display("FAIL rnd%0d_rd_cs got %0d want 0", it, cs_mismatch); else n_pass++;
    end
  endtask

`ifdef FIFO_STREAM_READER_LAST_EN
  task automatic test_last();
    bit seen_done;
    seen_done = 1'b0;
    flush();
    m_ready = 1'b1;
    fifo_write_words(5, '0, 1'b1);
    start = 1'b1; burst_len = LEN_WIDTH'(5);
    for (int c = 0; c < 60 && !seen_done; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      m_ready = (c % 2 == 1);
      #1;
      if (done) seen_done = 1'b1;
    end
    tick();
    n_total++; if (!seen_done) $display("FAIL last_timeout got no done want done"); else n_pass++;
    n_total++; if (got_last_q.size() !== 5) $display("FAIL last_count got %0d want 5", got_last_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < got_last_q.size(); i++) begin
      n_total++; if (got_last_q[i] !== (i == 4)) $display("FAIL last_word%0d got %b want %b", i, got_last_q[i], (i == 4)); else n_pass++;
    end
    n_total++; if (last_no_valid !== 0) $display("FAIL last_without_valid got %0d want 0", last_no_valid); else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_burst4();
    test_zero_len();
    test_backpressure();
    test_slow_fifo();
    test_reset_mid();
    test_random();
`ifdef FIFO_STREAM_READER_LAST_EN
    test_last();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
